// File: rtl/ddr_capture_if.sv
// Read-side handshake of the DDR capture block: head-of-FIFO word with valid/ready.
interface ddr_capture_if #(
  parameter int W = 16
);
  logic [W-1:0] DOUT;
  logic         DVALID;
  logic         DREADY;

  modport master (output DOUT, output DVALID, input DREADY);
  modport slave  (input DOUT, input DVALID, output DREADY);
endinterface

// File: rtl/ddr_capture.sv
// Pin sampler for DDR responses: even samples are D0 slots, odd samples are D1 slots,
// deserialized into words and buffered in a first-word-fall-through FIFO.
module ddr_capture #(
  parameter int WORD_PAIRS  = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        EN,
  input  logic                        START,
  input  logic                        PIN,
  ddr_capture_if.master               rd,
  output logic [$clog2(FIFO_DEPTH):0] COUNT,
  output logic                        OVERFLOW,
  input  logic                        CLR_OVF,
  output logic                        BUSY
);
  localparam int W    = 2 * WORD_PAIRS;
  localparam int CW   = $clog2(W);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = AW + 1;
  localparam logic [CW-1:0]   LAST = CW'(W - 1);
  localparam logic [CNTW-1:0] FULL = CNTW'(FIFO_DEPTH);

  typedef enum logic {IDLE, CAPTURE} state_t;

  state_t                         state, state_nxt;
  logic [SYNC_STAGES-1:0][2:0]    dly;
  logic [SYNC_STAGES:0][2:0]      dly_sh;
  logic                           pin_s, en_d, start_d;
  logic [CW-1:0]                  cnt, cnt_nxt;
  logic [W-1:0]                   shreg, shreg_nxt;
  logic                           push_req;
  logic [W-1:0]                   mem [FIFO_DEPTH];
  logic [AW-1:0]                  wr_ptr, rd_ptr;
  logic                           pop, full, push, drop;

  // EN and START ride the same pipeline as PIN so all three stay aligned.
  assign dly_sh = {dly, {START, EN, PIN}};
  assign {start_d, en_d, pin_s} = dly[SYNC_STAGES-1];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) dly <= '0;
    else     dly <= dly_sh[SYNC_STAGES-1:0];
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      cnt   <= '0;
      shreg <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      shreg <= shreg_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    shreg_nxt = shreg;
    push_req  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_d && en_d) begin
          state_nxt = CAPTURE;
          cnt_nxt   = '0;
          shreg_nxt = '0;
        end
      end
      CAPTURE: begin
        if (cnt == LAST) begin
          // Last slot completes the word; en_d only decides whether another follows.
          shreg_nxt[cnt] = pin_s;
          push_req       = 1'b1;
          cnt_nxt        = '0;
          state_nxt      = en_d ? CAPTURE : IDLE;
        end else if (!en_d) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          shreg_nxt[cnt] = pin_s;
          cnt_nxt        = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign BUSY      = (state == CAPTURE);
  assign rd.DVALID = (COUNT != '0);
  assign rd.DOUT   = rd.DVALID ? mem[rd_ptr] : '0;
  assign full      = (COUNT == FULL);
  assign pop       = rd.DVALID && rd.DREADY;
  assign push      = push_req && (!full || pop);
  assign drop      = push_req && full && !pop;

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= shreg_nxt;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      COUNT    <= '0;
      OVERFLOW <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      COUNT <= COUNT + 1'b1;
      else if (pop && !push) COUNT <= COUNT - 1'b1;
      if (drop)         OVERFLOW <= 1'b1;
      else if (CLR_OVF) OVERFLOW <= 1'b0;
    end
  end
endmodule

// File: doc/ddr_capture.md
# ddr_capture

Receive-side counterpart of the tester's DDR output path. It samples a DUT response pin once per CLK, treating even samples as the rising-edge (D0) slot and odd samples as the falling-edge (D1) slot. It deserializes D0/D1 pairs into words and buffers them in a small first-word-fall-through FIFO with a valid/ready read port. It sits between the pin's IOBUF input (O) and the tester's result collection logic. CLK runs at twice the vector rate, matching the clock that drives the transmit-side C0/C1 slots.

## Interface
- WORD_PAIRS, 8: D0/D1 pairs per word; word width W = 2*WORD_PAIRS.
- FIFO_DEPTH, 4: words buffered; power of two, at least 2.
- SYNC_STAGES, 2: flops on PIN before capture; at least 1.

- CLK  input  1  sole clock; all logic on rising edge.
- RST  input  1  asynchronous, active-high reset.
- EN  input  1  capture enable; high while the pin is in input mode (IOBUF T high).
- START  input  1  single-cycle pulse that aligns a frame; the first captured sample is the D0 slot of pair 0.
- PIN  input  1  raw pin value from the IOBUF O output.
- DOUT  output  W  head-of-FIFO word; bit 2k = D0 of pair k, bit 2k+1 = D1 of pair k.
- DVALID  output  1  FIFO not empty; DOUT is valid.
- DREADY  input  1  consumer accepts DOUT when DVALID is high on the same edge.
- COUNT  output  clog2(FIFO_DEPTH)+1  words currently held.
- OVERFLOW  output  1  sticky; a completed word was dropped because the FIFO was full.
- CLR_OVF  input  1  synchronous clear of OVERFLOW.
- BUSY  output  1  capture state machine is in CAPTURE.

## Operation
- **Synchronizer.** PIN passes through SYNC_STAGES flops. EN and START pass through an identical delay pipeline so their alignment to PIN is preserved. All capture decisions use the delayed versions (en_d, start_d, pin_s).
- **States.** IDLE and CAPTURE.
  - IDLE -> CAPTURE when start_d and en_d are both high. The bit counter clears to 0 and the shift register clears.
  - In CAPTURE, each cycle pin_s is stored at bit position `cnt` and `cnt` increments. The bit with `cnt` even is a D0 slot; `cnt` odd is a D1 slot.
  - When `cnt` = W-1, the completed word is pushed to the FIFO and `cnt` wraps to 0.
  - At a word boundary: if en_d is still high, stay in CAPTURE (continuous back-to-back words, no gap cycle). If en_d is low, go to IDLE.
  - en_d falling mid-word discards the partial word, returns to IDLE, and pushes nothing.
  - start_d while in CAPTURE is ignored; it does not realign the frame.
- **FIFO behaviour.**
  - Pop when DVALID && DREADY.
  - Push when a word completes. If the FIFO is full and no pop occurs that cycle, the word is dropped and OVERFLOW is set.
  - Push and pop on the same edge when full: both occur, no overflow, COUNT unchanged.
  - Push and pop on the same edge otherwise: COUNT unchanged, head advances.
  - Pointers wrap modulo FIFO_DEPTH.
  - Full is COUNT = FIFO_DEPTH; empty is COUNT = 0.
- **OVERFLOW flag.**
  - Cleared by CLR_OVF. If CLR_OVF and a new drop occur on the same edge, the drop wins and OVERFLOW stays 1.
  - The FIFO contents are unaffected by an overflow.

## Timing
- **Reset.** RST asserted clears all state asynchronously: IDLE, `cnt` = 0, synchronizer and delay flops = 0, FIFO empty. Outputs read DOUT = 0, DVALID = 0, COUNT = 0, OVERFLOW = 0, BUSY = 0. Reset mid-frame loses the partial word and all buffered words.
- **Sample indexing.** START high (with EN high) at edge n makes bit i equal to PIN as sampled at edge n+1+i, for i = 0..W-1.
- **BUSY.** Rises after edge n+SYNC_STAGES.
- **Push and DVALID latency.** The word is pushed at edge n+W+SYNC_STAGES. DVALID and COUNT update after that edge; there is no same-cycle bypass.
- **Continuous capture.** With EN held high, word j is pushed at edge n+W*(j+1)+SYNC_STAGES.
- **Read latency.** After a pop, DOUT shows the next word combinationally from the FIFO head in the following cycle.
- **End of capture.** EN must be deasserted before the next START to begin a fresh frame.

## Test plan
- **Basic capture.** Defaults; RST then START with EN=1; drive PIN with alternating D0/D1 values giving 0xA5C3 (LSB first) -> DVALID rises at START edge +18, DOUT = 0xA5C3, COUNT = 1, BUSY = 1.
- **Back-to-back words.** EN held high, DREADY=1, 3 words 0x0001, 0x8000, 0xFFFF -> pushes 16 cycles apart, each word popped in order, COUNT never exceeds 1.
- **Overflow.** DREADY=0, 5 words -> COUNT = 4, OVERFLOW = 1, DOUT = first word. Pulse CLR_OVF -> OVERFLOW = 0.
- **Full push/pop same edge.** FIFO full, DREADY=1 on the push edge -> no overflow, COUNT stays 4, order preserved.
- **Mid-word abort.** EN dropped after 7 bits -> BUSY falls, COUNT = 0. A new START then yields a correctly aligned word.
- **Reset mid-operation.** RST asserted mid-frame with 2 words buffered -> all outputs 0 immediately, no DVALID until a new START plus 18 cycles.
